// File: rtl/retospect_clockgen.sv
// retospect_clockgen: programmable decay-clock generator for the neuron fabric.
// It drives the shared clockbus. Each channel has a period (max+1 enabled
// cycles), a restart phase and a periodic/one-shot mode. All configuration is
// held in one serial shift chain at the head of the fabric bitstream.
module retospect_clockgen #(
    parameter int NUM_CH = 6,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reset_nn,
    input  logic              config_en,
    input  logic              bs_in,
    output logic              bs_out,
    input  logic              tick_en,
    output logic [NUM_CH+1:0] clockbus,
    output logic [NUM_CH-1:0] done
);

    // Layout of one channel inside the chain, counted from the entry point:
    // max MSB..LSB, phase MSB..LSB, mode.
    localparam int CH_BITS   = 2 * CNT_W + 1;
    localparam int CHAIN_LEN = NUM_CH * CH_BITS;

    genvar gi, gj;

    // Chain position 0 is next to bs_in. The last position (channel NUM_CH-1
    // mode) feeds bs_out.
    logic [CHAIN_LEN-1:0] chain_reg;

    // Counters stay idle after a full reset until the first network restart.
    // Otherwise the all-zero configuration (max=0) would pulse on every tick.
    logic armed_reg;

    logic [NUM_CH-1:0] pulse_vec;
    logic [NUM_CH-1:0] done_vec;

    // Configuration shift chain. A network restart has priority over shifting
    // and leaves any partially shifted bits in place.
    always_ff @(posedge clk) begin
        if (reset) begin
            chain_reg <= '0;
        end else if (!reset_nn && config_en) begin
            chain_reg <= {chain_reg[CHAIN_LEN-2:0], bs_in};
        end
    end

    // Arm the counters on the first network restart after a full reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            armed_reg <= 1'b0;
        end else if (reset_nn) begin
            armed_reg <= 1'b1;
        end
    end

    assign bs_out = chain_reg[CHAIN_LEN-1];

    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            localparam int BASE = gi * CH_BITS;

            logic [CNT_W-1:0] max_val;
            logic [CNT_W-1:0] phase_val;
            logic [CNT_W-1:0] start_val;
            logic             mode_val;
            logic [CNT_W-1:0] cnt_reg;
            logic             done_reg;
            logic             pulse_reg;

            // Fields are stored MSB-first along the shift path.
            for (gj = 0; gj < CNT_W; gj++) begin : g_bit
                assign max_val[CNT_W-1-gj]   = chain_reg[BASE+gj];
                assign phase_val[CNT_W-1-gj] = chain_reg[BASE+CNT_W+gj];
            end
            assign mode_val = chain_reg[BASE+2*CNT_W];

            // A phase beyond the wrap point is treated as a start from zero.
            assign start_val = (phase_val <= max_val) ? phase_val : '0;

            // Channel counter, one-shot latch and registered pulse.
            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_reg   <= '0;
                    done_reg  <= 1'b0;
                    pulse_reg <= 1'b0;
                end else if (reset_nn) begin
                    cnt_reg   <= start_val;
                    done_reg  <= 1'b0;
                    pulse_reg <= 1'b0;
                end else if (config_en) begin
                    pulse_reg <= 1'b0;
                end else if (tick_en && armed_reg) begin
                    if (done_reg) begin
                        pulse_reg <= 1'b0;
                    end else if (cnt_reg == max_val) begin
                        pulse_reg <= 1'b1;
                        cnt_reg   <= '0;
                        if (mode_val) begin
                            done_reg <= 1'b1;
                        end
                    end else begin
                        // If max was lowered below cnt, this wraps through
                        // all-ones back to zero.
                        cnt_reg   <= cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
                        pulse_reg <= 1'b0;
                    end
                end else begin
                    pulse_reg <= 1'b0;
                end
            end

            assign pulse_vec[gi] = pulse_reg;
            assign done_vec[gi]  = done_reg;
        end
    endgenerate

    assign clockbus = {pulse_vec, 1'b1, 1'b0};
    assign done     = done_vec;

endmodule

// File: tb/tb_retospect_clockgen.sv
// Testbench for retospect_clockgen. A queue-based reference model tracks the
// chain and per-channel timing. It is compared every cycle and backed by
// latency checks derived from the period formula.
module tb_retospect_clockgen;

    localparam int NUM_CH    = 6;
    localparam int CNT_W     = 8;
    localparam int CH_BITS   = 2 * CNT_W + 1;
    localparam int CHAIN_LEN = NUM_CH * CH_BITS;

    logic              clk = 1'b0;
    logic              reset;
    logic              reset_nn;
    logic              config_en;
    logic              bs_in;
    logic              tick_en;
    logic              bs_out;
    logic [NUM_CH+1:0] clockbus;
    logic [NUM_CH-1:0] done;

    int total = 0;
    int bad   = 0;

    retospect_clockgen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .reset_nn (reset_nn),
        .config_en(config_en),
        .bs_in    (bs_in),
        .bs_out   (bs_out),
        .tick_en  (tick_en),
        .clockbus (clockbus),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Reference model state.
    bit chain_q[$];
    int m_cnt   [NUM_CH];
    bit m_done  [NUM_CH];
    bit m_pulse [NUM_CH];
    bit m_armed;

    // Intended configuration for load_cfg.
    int c_max  [NUM_CH];
    int c_ph   [NUM_CH];
    int c_mode [NUM_CH];

    // Measurement results from run_ticks.
    int first_t  [NUM_CH];
    int second_t [NUM_CH];
    int cnt_p    [NUM_CH];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int field(int k, int off, int width);
        int v = 0;
        for (int j = 0; j < width; j++) v = (v << 1) | int'(chain_q[k*CH_BITS + off + j]);
        return v;
    endfunction

    task automatic model_update();
        if (reset) begin
            chain_q.delete();
            for (int i = 0; i < CHAIN_LEN; i++) chain_q.push_back(1'b0);
            for (int k = 0; k < NUM_CH; k++) begin
                m_cnt[k] = 0; m_done[k] = 0; m_pulse[k] = 0;
            end
            m_armed = 0;
        end else if (reset_nn) begin
            for (int k = 0; k < NUM_CH; k++) begin
                int mx = field(k, 0, CNT_W);
                int ph = field(k, CNT_W, CNT_W);
                m_cnt[k]   = (ph <= mx) ? ph : 0;
                m_done[k]  = 0;
                m_pulse[k] = 0;
            end
            m_armed = 1;
        end else if (config_en) begin
            chain_q.push_front(bs_in);
            void'(chain_q.pop_back());
            for (int k = 0; k < NUM_CH; k++) m_pulse[k] = 0;
        end else if (tick_en && m_armed) begin
            for (int k = 0; k < NUM_CH; k++) begin
                int mx = field(k, 0, CNT_W);
                int md = field(k, 2*CNT_W, 1);
                if (m_done[k]) begin
                    m_pulse[k] = 0;
                end else if (m_cnt[k] == mx) begin
                    m_pulse[k] = 1;
                    m_cnt[k]   = 0;
                    if (md == 1) m_done[k] = 1;
                end else begin
                    m_cnt[k]   = (m_cnt[k] + 1) % (1 << CNT_W);
                    m_pulse[k] = 0;
                end
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) m_pulse[k] = 0;
        end
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic step();
        logic [63:0] exp_bus;
        logic [63:0] exp_done;
        @(posedge clk);
        model_update();
        @(negedge clk);
        exp_bus  = 64'd2;
        exp_done = 64'd0;
        for (int k = 0; k < NUM_CH; k++) begin
            exp_bus[k+2] = m_pulse[k];
            exp_done[k]  = m_done[k];
        end
        check("clockbus", 64'(clockbus), exp_bus);
        check("done", 64'(done), exp_done);
        check("bs_out", 64'(bs_out), 64'(chain_q[CHAIN_LEN-1]));
    endtask

    // Shift the full configuration so that chain position p gets its bit last.
    task automatic load_cfg();
        config_en = 1'b1;
        for (int p = CHAIN_LEN - 1; p >= 0; p--) begin
            int k   = p / CH_BITS;
            int off = p % CH_BITS;
            if (off < CNT_W)        bs_in = 1'((c_max[k] >> (CNT_W - 1 - off)) & 1);
            else if (off < 2*CNT_W) bs_in = 1'((c_ph[k] >> (CNT_W - 1 - (off - CNT_W))) & 1);
            else                    bs_in = 1'(c_mode[k] & 1);
            step();
        end
        config_en = 1'b0;
        bs_in     = 1'b0;
    endtask

    task automatic restart();
        reset_nn = 1'b1;
        step();
        reset_nn = 1'b0;
    endtask

    // Run n cycles after a restart, freezing tick_en on cycles flo..fhi.
    // Record pulse times per channel.
    task automatic run_ticks(input int n, input int flo, input int fhi);
        for (int k = 0; k < NUM_CH; k++) begin
            first_t[k] = -1; second_t[k] = -1; cnt_p[k] = 0;
        end
        for (int t = 1; t <= n; t++) begin
            tick_en = (t >= flo && t <= fhi) ? 1'b0 : 1'b1;
            step();
            for (int k = 0; k < NUM_CH; k++) begin
                if (clockbus[k+2]) begin
                    cnt_p[k]++;
                    if (first_t[k] < 0)       first_t[k] = t;
                    else if (second_t[k] < 0) second_t[k] = t;
                end
            end
        end
        tick_en = 1'b1;
    endtask

    initial begin
        int rise;
        int sum;
        for (int i = 0; i < CHAIN_LEN; i++) chain_q.push_back(1'b0);
        m_armed   = 0;
        reset     = 1'b1;
        reset_nn  = 1'b0;
        config_en = 1'b0;
        bs_in     = 1'b0;
        tick_en   = 1'b1;

        // Reset: constant bus bits only, and no pulses before a restart.
        step();
        step();
        reset = 1'b0;
        run_ticks(20, 1, 0);
        sum = 0;
        for (int k = 0; k < NUM_CH; k++) sum += cnt_p[k];
        check("idle_pulses", 64'(sum), 64'd0);
        $display("reset: 20 idle tick cycles, %0d pulses", sum);

        // Chain length: a single 1 reaches bs_out on shift CHAIN_LEN.
        rise      = -1;
        config_en = 1'b1;
        bs_in     = 1'b1;
        step();
        if (bs_out) rise = 1;
        bs_in = 1'b0;
        for (int n = 2; n <= 120; n++) begin
            step();
            if (bs_out && rise < 0) rise = n;
        end
        config_en = 1'b0;
        check("chain_len", 64'(rise), 64'd102);
        $display("chain: bs_out rose on shift %0d", rise);
        reset = 1'b1;
        step();
        reset = 1'b0;

        // Channel setup: periodic with phase, every-cycle, one-shot, freeze
        // target, clamped phase, near full-range period.
        c_max[0] = 3;   c_ph[0] = 1;   c_mode[0] = 0;
        c_max[1] = 0;   c_ph[1] = 0;   c_mode[1] = 0;
        c_max[2] = 4;   c_ph[2] = 0;   c_mode[2] = 1;
        c_max[3] = 5;   c_ph[3] = 0;   c_mode[3] = 0;
        c_max[4] = 5;   c_ph[4] = 9;   c_mode[4] = 0;
        c_max[5] = 255; c_ph[5] = 250; c_mode[5] = 0;
        load_cfg();
        restart();
        run_ticks(40, 1, 0);
        check("lat_ch0", 64'(first_t[0]), 64'd3);
        check("per_ch0", 64'(second_t[0] - first_t[0]), 64'd4);
        check("npulse_ch0", 64'(cnt_p[0]), 64'd10);
        check("lat_ch1", 64'(first_t[1]), 64'd1);
        check("npulse_ch1", 64'(cnt_p[1]), 64'd40);
        check("lat_ch2", 64'(first_t[2]), 64'd5);
        check("npulse_ch2", 64'(cnt_p[2]), 64'd1);
        check("done_ch2", 64'(done[2]), 64'd1);
        check("lat_ch4_clamp", 64'(first_t[4]), 64'd6);
        check("lat_ch5", 64'(first_t[5]), 64'd6);
        $display("periodic: ch0 first=%0d ch1 first=%0d ch2 first=%0d ch4 first=%0d",
                 first_t[0], first_t[1], first_t[2], first_t[4]);

        // One-shot rearm.
        restart();
        check("done_ch2_clr", 64'(done[2]), 64'd0);
        run_ticks(10, 1, 0);
        check("rearm_lat_ch2", 64'(first_t[2]), 64'd5);
        check("rearm_npulse_ch2", 64'(cnt_p[2]), 64'd1);
        $display("oneshot: rearmed pulse at %0d", first_t[2]);

        // Freeze of 7 cycles mid-count on a max=5 channel.
        restart();
        run_ticks(30, 3, 9);
        check("freeze_first_ch3", 64'(first_t[3]), 64'd13);
        check("freeze_period_ch3", 64'(second_t[3]), 64'd19);
        $display("freeze: ch3 pulses at %0d and %0d", first_t[3], second_t[3]);

        // Restart together with config_en: reload wins and nothing shifts.
        reset_nn  = 1'b1;
        config_en = 1'b1;
        bs_in     = 1'b1;
        step();
        reset_nn  = 1'b0;
        config_en = 1'b0;
        bs_in     = 1'b0;
        run_ticks(12, 1, 0);
        check("prio_lat_ch0", 64'(first_t[0]), 64'd3);
        check("prio_lat_ch4", 64'(first_t[4]), 64'd6);
        $display("priority: ch0 first=%0d ch4 first=%0d", first_t[0], first_t[4]);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 199) == 0);
            reset_nn  = ($urandom_range(0, 39) == 0);
            config_en = ($urandom_range(0, 7) == 0);
            tick_en   = ($urandom_range(0, 3) != 0);
            bs_in     = 1'($urandom_range(0, 1));
            step();
        end
        reset = 1'b0; reset_nn = 1'b0; config_en = 1'b0;
        $display("random: 3000 cycles checked");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
